spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_master_if.sv | 27 ++
 rtl/spi_shift_reg.sv | 35 +++
 rtl/spi_master.sv | 143 ++++++++++++++
 tb/tb_spi_master.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master
// Purpose: FSM state encoding, frame command encodings and frame width,
//          used by spi_master and spi_shift_reg.
package spi_pkg;

  localparam int FRAME_W = 10;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SHIFT_OUT,
    WAIT,
    SHIFT_IN,
    GAP
  } state_t;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host request and SPI pin bundle for spi_master
// Purpose: groups the host handshake (start/cmd/wdata/ready/rdata/rdata_valid)
//          and the SPI pins (SS_n/MOSI/MISO).
// Modports: master - the spi_master side; slave - host + SPI slave side.
interface spi_master_if;

  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       ready;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, cmd, wdata, MISO,
    output ready, rdata, rdata_valid, SS_n, MOSI
  );

  modport slave (
    output start, cmd, wdata, MISO,
    input  ready, rdata, rdata_valid, SS_n, MOSI
  );

endinterface

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - frame shifter: parallel-load/serial-out, serial-in/parallel-out
// Ports: clk, rst_n (async active-low); load + load_data parallel load (wins
//        over shift); shift_en shifts left taking sin into bit 0; sout is the
//        MSB; pdata is the full register contents.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         sin,
  output logic         sout,
  output logic [W-1:0] pdata
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[W-2:0], sin};
    end
  end

  assign sout  = q[W-1];
  assign pdata = q;

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte SPI master with command/wait/read-back framing
// Parameters: READ_WAIT idle cycles before the first MISO sample (1..7),
//             IDLE_GAP cycles SS_n stays high before ready returns (1..7).
// Ports: clk, rst_n (async active-low); bus (spi_master_if.master):
//        start/cmd/wdata request, ready idle flag, rdata/rdata_valid read
//        result, SS_n/MOSI/MISO SPI pins.
module spi_master
  import spi_pkg::*;
#(
  parameter int READ_WAIT = 2,
  parameter int IDLE_GAP  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         cmd_q;
  logic [7:0]         rdata_q;
  logic               rdata_valid_q;
  logic               sh_load;
  logic               sh_en;
  logic               done_rd;
  logic               sh_sout;
  logic [FRAME_W-1:0] sh_pdata;
  logic               unused_shift_bits;

  // One register serves both directions: the frame leaves from the MSB end
  // while MISO enters at bit 0, so after a read the byte sits in the low bits.
  spi_shift_reg #(.W(FRAME_W)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_data ({bus.cmd, bus.wdata}),
    .shift_en  (sh_en),
    .sin       (bus.MISO),
    .sout      (sh_sout),
    .pdata     (sh_pdata)
  );

  assign unused_shift_bits = ^sh_pdata[FRAME_W-1:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_q         <= CMD_WR_ADDR;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rdata_valid_q <= done_rd;
      if (sh_load) begin
        cmd_q <= bus.cmd;
      end
      // The last MISO bit is captured directly so rdata updates on the same
      // edge as the final shift.
      if (done_rd) begin
        rdata_q <= {sh_pdata[6:0], bus.MISO};
      end
    end
  end

  // cnt_q holds the remaining cycles in the current state minus one; it is
  // reloaded on every state entry and leaves the state at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_load = 1'b0;
    sh_en   = 1'b0;
    done_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CMD;
          cnt_d   = '0;
          sh_load = 1'b1;
        end
      end
      CMD: begin
        // MOSI already shows frame[9] (= cmd[1]); it is repeated as the
        // first SHIFT_OUT bit, so no shift on this edge.
        state_d = SHIFT_OUT;
        cnt_d   = 4'(FRAME_W - 1);
      end
      SHIFT_OUT: begin
        sh_en = 1'b1;
        if (cnt_q == 4'd0) begin
          if (cmd_q == CMD_RD_DATA) begin
            state_d = WAIT;
            cnt_d   = 4'(READ_WAIT - 1);
          end else begin
            state_d = GAP;
            cnt_d   = 4'(IDLE_GAP - 1);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = SHIFT_IN;
          cnt_d   = 4'd7;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SHIFT_IN: begin
        sh_en = 1'b1;
        if (cnt_q == 4'd0) begin
          done_rd = 1'b1;
          state_d = GAP;
          cnt_d   = 4'(IDLE_GAP - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin outputs decode straight from state so reset forces them at once.
  assign bus.ready       = (state_q == IDLE);
  assign bus.SS_n        = (state_q == IDLE) || (state_q == GAP);
  assign bus.MOSI        = ((state_q == CMD) || (state_q == SHIFT_OUT)) ? sh_sout : 1'b0;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with slave+RAM model
module tb_spi_master;

  localparam int RW   = 2;
  localparam int IG   = 1;
  localparam int NOBS = 24;

  logic clk = 1'b0;
  logic rst_n;

  spi_master_if bus();

  spi_master #(.READ_WAIT(RW), .IDLE_GAP(IG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [256];
  logic [7:0] addr_m;
  logic [7:0] rdata_m;

  typedef struct {
    logic [1:0]  c;
    logic [7:0]  d;
    logic [10:0] mosi;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, " ready timeout"}, 64'd0, 64'd1);
  endtask

  // Slave + RAM: write/read-address set the pointer, write-data stores,
  // read-data returns the stored byte.
  task automatic model_update(input logic [1:0] c, input logic [7:0] d);
    case (c)
      2'b00, 2'b10: addr_m = d;
      2'b01:        ram[addr_m] = d;
      default:      rdata_m = ram[addr_m];
    endcase
  endtask

  // One frame, observed at each falling edge k = cycle after edge E0+k.
  task automatic run_frame(input logic [1:0] c, input logic [7:0] d,
                           input logic [10:0] exp_mosi, input logic [7:0] exp_rd,
                           input string tag);
    logic [63:0] o_ss, o_mosi, o_rdy, o_val;
    logic [63:0] e_ss, e_mosi, e_rdy, e_val, mask;
    logic [7:0]  miso_byte;
    int          last, rdy_at, win;
    bit          rd;
    rd        = (c == 2'b11);
    miso_byte = ram[addr_m];
    last      = rd ? 11 + RW + 8 : 11;
    rdy_at    = last + IG;
    win       = 11 + RW;
    o_ss = '0; o_mosi = '0; o_rdy = '0; o_val = '0;
    e_ss = '0; e_mosi = '0; e_rdy = '0; e_val = '0; mask = '0;
    wait_ready(tag);
    bus.start = 1'b1;
    bus.cmd   = c;
    bus.wdata = d;
    for (int k = 0; k < NOBS; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start = 1'b0;
        bus.cmd   = 2'($urandom);
        bus.wdata = 8'($urandom);
      end
      o_ss[k]   = bus.SS_n;
      o_mosi[k] = bus.MOSI;
      o_rdy[k]  = bus.ready;
      o_val[k]  = bus.rdata_valid;
      if (rd && k >= win && k <= win + 7) bus.MISO = miso_byte[win + 7 - k];
      else                                bus.MISO = 1'($urandom);
      e_ss[k]  = (k >= last);
      e_rdy[k] = (k >= rdy_at);
      e_val[k] = rd && (k == last);
      if (k <= 10) begin
        e_mosi[k] = exp_mosi[10 - k];
        mask[k]   = 1'b1;
      end else if (k >= last) begin
        mask[k] = 1'b1;
      end
    end
    check({tag, " SS_n"}, o_ss, e_ss);
    check({tag, " MOSI"}, o_mosi & mask, e_mosi);
    check({tag, " ready"}, o_rdy, e_rdy);
    check({tag, " rdata_valid"}, o_val, e_val);
    check({tag, " ready&valid"}, o_rdy & o_val, 64'd0);
    check({tag, " rdata"}, 64'(bus.rdata), 64'(exp_rd));
    model_update(c, d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] o_ss, o_rdy, o_val, e_ss, e_rdy;
    logic [1:0]  rc;
    logic [7:0]  rw;
    logic [7:0]  w;

    tbl[0]  = '{2'b00, 8'hA5, 11'b0_00_1010_0101, 8'h00};
    tbl[1]  = '{2'b01, 8'h3C, 11'b0_01_0011_1100, 8'h00};
    tbl[2]  = '{2'b00, 8'h20, 11'b0_00_0010_0000, 8'h00};
    tbl[3]  = '{2'b01, 8'hC3, 11'b0_01_1100_0011, 8'h00};
    tbl[4]  = '{2'b10, 8'h20, 11'b1_10_0010_0000, 8'h00};
    tbl[5]  = '{2'b11, 8'h5A, 11'b1_11_0101_1010, 8'hC3};
    tbl[6]  = '{2'b00, 8'h10, 11'b0_00_0001_0000, 8'hC3};
    tbl[7]  = '{2'b01, 8'h77, 11'b0_01_0111_0111, 8'hC3};
    tbl[8]  = '{2'b10, 8'h10, 11'b1_10_0001_0000, 8'hC3};
    tbl[9]  = '{2'b11, 8'h00, 11'b1_11_0000_0000, 8'h77};
    tbl[10] = '{2'b10, 8'hA5, 11'b1_10_1010_0101, 8'h77};
    tbl[11] = '{2'b11, 8'hFF, 11'b1_11_1111_1111, 8'h3C};

    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    addr_m  = 8'h00;
    rdata_m = 8'h00;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.cmd   = 2'b00;
    bus.wdata = 8'h00;
    bus.MISO  = 1'b0;
    #22;
    check("reset ready", 64'(bus.ready), 64'd1);
    check("reset SS_n", 64'(bus.SS_n), 64'd1);
    check("reset MOSI", 64'(bus.MOSI), 64'd0);
    check("reset rdata_valid", 64'(bus.rdata_valid), 64'd0);
    check("reset rdata", 64'(bus.rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_frame(tbl[i].c, tbl[i].d, tbl[i].mosi, tbl[i].rd, $sformatf("vec%0d", i));
    end

    // start held high: one frame per ready window, period 11 + IG + 1.
    wait_ready("cont");
    w = 8'($urandom);
    bus.start = 1'b1;
    bus.cmd   = 2'b00;
    bus.wdata = w;
    o_ss = '0; o_rdy = '0; o_val = '0; e_ss = '0; e_rdy = '0;
    for (int k = 0; k < 39; k++) begin
      @(negedge clk);
      o_ss[k]  = bus.SS_n;
      o_rdy[k] = bus.ready;
      o_val[k] = bus.rdata_valid;
      e_ss[k]  = ((k % 13) >= 11);
      e_rdy[k] = ((k % 13) == 12);
    end
    bus.start = 1'b0;
    check("cont SS_n", o_ss, e_ss);
    check("cont ready", o_rdy, e_rdy);
    check("cont rdata_valid", o_val, 64'd0);
    model_update(2'b00, w);

    for (int i = 0; i < 30; i++) begin
      rc = 2'($urandom_range(0, 3));
      rw = 8'($urandom);
      run_frame(rc, rw, {rc[1], rc, rw}, (rc == 2'b11) ? ram[addr_m] : rdata_m,
                $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a read-data frame.
    wait_ready("rst");
    bus.start = 1'b1;
    bus.cmd   = 2'b11;
    bus.wdata = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst SS_n", 64'(bus.SS_n), 64'd1);
    check("midrst MOSI", 64'(bus.MOSI), 64'd0);
    check("midrst ready", 64'(bus.ready), 64'd1);
    check("midrst rdata_valid", 64'(bus.rdata_valid), 64'd0);
    check("midrst rdata", 64'(bus.rdata), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    rdata_m = 8'h00;
    o_ss = '0; o_val = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      o_ss[k]  = bus.SS_n;
      o_val[k] = bus.rdata_valid;
    end
    check("postrst SS_n", o_ss, (64'd1 << 25) - 64'd1);
    check("postrst rdata_valid", o_val, 64'd0);
    run_frame(2'b11, 8'h00, 11'b1_11_0000_0000, ram[addr_m], "postrst read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
